demux_1to4_stream: RTL and testbench

- Registered 1-to-4 stream demultiplexer. It is the distribution counterpart of the 4-to-1 select mux in the same IP repository.
- Accepts one tagged transaction per cycle on a single valid/ready input and routes it, by 2-bit select, to one of four independent output channels.
- Each output channel has one holding register. Each channel also has a delivered-transaction counter that the performance-monitor logic reads.
- Sits between the scheduler dispatch point and the four per-core request paths.

---
 rtl/memoredf_pkg.sv | 10 +
 rtl/demux_out_slot.sv | 47 ++++
 rtl/demux_1to4_stream.sv | 50 +++++
 tb/tb_demux_1to4_stream.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memoredf_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package memoredf_pkg;

  localparam int NUM_CH     = 4;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 32;

  typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: holding register, valid flag and delivered-transaction counter.
module demux_out_slot
  import memoredf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ready,
  input  logic              cnt_clr,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt
);

  logic deliver;

  assign deliver = valid & ready;

  // Holding register: a same-edge accept wins over the deliver, so the slot streams without bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (acc) begin
      valid <= 1'b1;
      data  <= in_data;
    end else if (deliver) begin
      valid <= 1'b0;
    end
  end

  // Delivered count wraps; a clear on the same edge as a deliver discards that deliver.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (deliver) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demux: decodes s_ready from the selected slot and steers the accept.
module demux_1to4_stream
  import memoredf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [1:0]               s_sel,
  output logic [NUM_CH-1:0]        m_valid,
  input  logic [NUM_CH-1:0]        m_ready,
  output logic [NUM_CH*DATA_W-1:0] m_data,
  input  logic                     cnt_clr,
  output logic [NUM_CH*CNT_W-1:0]  cnt
);

  ch_sel_t           sel;
  logic [NUM_CH-1:0] acc;

  assign sel = s_sel;

  // Only the addressed channel's space may open the input.
  always_comb begin
    s_ready = ~m_valid[sel] | m_ready[sel];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    assign acc[i] = s_valid & s_ready & (sel == ch_sel_t'(i));

    demux_out_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .acc     (acc[i]),
      .in_data (s_data),
      .ready   (m_ready[i]),
      .cnt_clr (cnt_clr),
      .valid   (m_valid[i]),
      .data    (m_data[i*DATA_W +: DATA_W]),
      .cnt     (cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench for demux_1to4_stream: directed scenarios plus random traffic against a channel-array model.
module tb_demux_1to4_stream;

  localparam int DW = 16;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic [1:0]      s_sel;
  logic [3:0]      m_valid;
  logic [3:0]      m_ready;
  logic [4*DW-1:0] m_data;
  logic            cnt_clr;
  logic [4*CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  bit            mv[4];
  logic [DW-1:0] md[4];
  int            mc[4];

  demux_1to4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_sel   (s_sel),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .cnt_clr (cnt_clr),
    .cnt     (cnt)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return !mv[s_sel] || m_ready[s_sel];
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mv[i];
    return v;
  endfunction

  function automatic logic [4*DW-1:0] exp_data();
    logic [4*DW-1:0] d;
    for (int i = 0; i < 4; i++) d[i*DW +: DW] = md[i];
    return d;
  endfunction

  function automatic logic [4*CW-1:0] exp_cnt();
    logic [4*CW-1:0] c;
    for (int i = 0; i < 4; i++) c[i*CW +: CW] = mc[i][CW-1:0];
    return c;
  endfunction

  // Apply the transfer rules for the current inputs to the model, then clock the DUT.
  task automatic step();
    bit acc;
    bit dl;
    acc = s_valid && exp_ready() && !reset;
    for (int i = 0; i < 4; i++) begin
      dl = mv[i] && m_ready[i];
      if (reset) begin
        mv[i] = 1'b0;
        md[i] = '0;
        mc[i] = 0;
      end else begin
        if (cnt_clr) mc[i] = 0;
        else if (dl) mc[i] = (mc[i] + 1) % (1 << CW);
        if (acc && s_sel == i) begin
          mv[i] = 1'b1;
          md[i] = s_data;
        end else if (dl) begin
          mv[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b1; s_sel = 2'd0; s_data = DW'($urandom);
    m_ready = 4'h0; cnt_clr = 1'b0;
    step(); step();
    checks++; if (m_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%b exp=%b", m_valid, 4'h0); end
    checks++; if (cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", m_data); end
    reset = 1'b0; s_valid = 1'b0;
    step();
    checks++; if (m_valid !== 4'h0) begin failures++; $display("FAIL reset_no_accept got=%b exp=%b", m_valid, 4'h0); end
  endtask

  task automatic test_basic_route();
    m_ready = 4'hF; s_valid = 1'b1; s_sel = 2'd2; s_data = 16'hBEEF;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", s_ready); end
    step();
    s_valid = 1'b0;
    checks++; if (m_valid !== 4'b0100) begin failures++; $display("FAIL basic_valid got=%b exp=0100", m_valid); end
    checks++; if (m_data[2*DW +: DW] !== 16'hBEEF) begin failures++; $display("FAIL basic_data got=%h exp=beef", m_data[2*DW +: DW]); end
    step();
    checks++; if (m_valid !== 4'b0000) begin failures++; $display("FAIL basic_drain got=%b exp=0000", m_valid); end
    checks++; if (cnt[2*CW +: CW] !== 4'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", cnt[2*CW +: CW]); end
  endtask

  task automatic test_backpressure();
    m_ready = 4'b1101; s_valid = 1'b1; s_sel = 2'd1; s_data = 16'h0011;
    step();
    s_data = 16'h2222;
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_blocked got=%b exp=0", s_ready); end
    step();
    checks++; if (m_data[1*DW +: DW] !== 16'h0011 || m_valid[1] !== 1'b1) begin
      failures++; $display("FAIL bp_hold got=%h/%b exp=0011/1", m_data[1*DW +: DW], m_valid[1]);
    end
    s_sel = 2'd3; s_data = 16'h3333;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_other_ready got=%b exp=1", s_ready); end
    step();
    s_valid = 1'b0;
    checks++; if (m_valid !== 4'b1010 || m_data[3*DW +: DW] !== 16'h3333) begin
      failures++; $display("FAIL bp_other_route got=%b/%h exp=1010/3333", m_valid, m_data[3*DW +: DW]);
    end
    step();
    checks++; if (cnt[3*CW +: CW] !== 4'd1 || m_data[1*DW +: DW] !== 16'h0011) begin
      failures++; $display("FAIL bp_after got=%0d/%h exp=1/0011", cnt[3*CW +: CW], m_data[1*DW +: DW]);
    end
  endtask

  task automatic test_throughput();
    m_ready = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      s_valid = 1'b1; s_sel = 2'd0; s_data = DW'(k);
      #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL tput_ready k=%0d got=%b exp=1", k, s_ready); end
      step();
      checks++; if (m_valid[0] !== 1'b1 || m_data[DW-1:0] !== DW'(k)) begin
        failures++; $display("FAIL tput_word k=%0d got=%b/%h exp=1/%h", k, m_valid[0], m_data[DW-1:0], DW'(k));
      end
    end
    s_valid = 1'b0;
    step();
    checks++; if (cnt[CW-1:0] !== 4'd8 || m_valid[0] !== 1'b0) begin
      failures++; $display("FAIL tput_cnt got=%0d/%b exp=8/0", cnt[CW-1:0], m_valid[0]);
    end
  endtask

  task automatic test_simultaneous();
    m_ready = 4'b0000; s_valid = 1'b1; s_sel = 2'd3; s_data = 16'h1234;
    step();
    m_ready = 4'b1000; s_data = 16'hA5A5;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL sim_ready got=%b exp=1", s_ready); end
    step();
    s_valid = 1'b0; m_ready = 4'b0000;
    checks++; if (m_valid[3] !== 1'b1 || m_data[3*DW +: DW] !== 16'hA5A5) begin
      failures++; $display("FAIL sim_data got=%b/%h exp=1/a5a5", m_valid[3], m_data[3*DW +: DW]);
    end
    checks++; if (cnt[3*CW +: CW] !== 4'd2) begin failures++; $display("FAIL sim_cnt got=%0d exp=2", cnt[3*CW +: CW]); end
  endtask

  task automatic test_cnt_wrap();
    m_ready = 4'b0001; s_sel = 2'd0;
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1; s_data = DW'($urandom);
      step();
    end
    s_valid = 1'b0;
    step();
    checks++; if (cnt[CW-1:0] !== 4'd15) begin failures++; $display("FAIL wrap_pre got=%0d exp=15", cnt[CW-1:0]); end
    s_valid = 1'b1; s_data = 16'h0F0F;
    step();
    s_valid = 1'b0;
    step();
    checks++; if (cnt[CW-1:0] !== 4'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", cnt[CW-1:0]); end
  endtask

  task automatic test_clr_collision();
    m_ready = 4'b0010; cnt_clr = 1'b1; s_valid = 1'b0;
    step();
    cnt_clr = 1'b0; m_ready = 4'b0000;
    checks++; if (cnt[1*CW +: CW] !== 4'd0 || m_valid[1] !== 1'b0) begin
      failures++; $display("FAIL clr_collide got=%0d/%b exp=0/0", cnt[1*CW +: CW], m_valid[1]);
    end
    checks++; if (cnt !== '0) begin failures++; $display("FAIL clr_all got=%h exp=0", cnt); end
  endtask

  task automatic test_random();
    bit hold;
    s_valid = 1'b0; s_sel = 2'd0; s_data = '0;
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(49) == 0);
      cnt_clr = ($urandom_range(19) == 0);
      m_ready = 4'($urandom);
      #1;
      if (s_valid) begin
        checks++; if (s_ready !== exp_ready()) begin
          failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, s_ready, exp_ready());
        end
      end
      hold = s_valid && !exp_ready() && !reset;
      step();
      checks++; if (m_valid !== exp_valid()) begin failures++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, m_valid, exp_valid()); end
      checks++; if (m_data !== exp_data()) begin failures++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, m_data, exp_data()); end
      checks++; if (cnt !== exp_cnt()) begin failures++; $display("FAIL rand_cnt n=%0d got=%h exp=%h", n, cnt, exp_cnt()); end
      if (!hold) begin
        s_valid = ($urandom_range(3) != 0);
        s_sel   = 2'($urandom);
        s_data  = DW'($urandom);
      end
    end
    reset = 1'b0; cnt_clr = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ready = 4'hF; s_valid = 1'b0;
    step(); step();
    m_ready = 4'h0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_sel = 2'(i); s_data = DW'($urandom);
      step();
    end
    checks++; if (m_valid !== 4'hF) begin failures++; $display("FAIL mid_fill got=%b exp=1111", m_valid); end
    reset = 1'b1; s_valid = 1'b1; s_sel = 2'd0; s_data = 16'h7777;
    step();
    checks++; if (m_valid !== 4'h0 || cnt !== '0) begin
      failures++; $display("FAIL mid_reset got=%b/%h exp=0000/0", m_valid, cnt);
    end
    reset = 1'b0; s_valid = 1'b0;
    step();
    checks++; if (m_valid !== 4'h0 || m_data !== '0) begin
      failures++; $display("FAIL mid_no_ghost got=%b/%h exp=0000/0", m_valid, m_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; md[i] = '0; mc[i] = 0;
    end
    reset = 1'b1; s_valid = 1'b0; s_sel = 2'd0; s_data = '0;
    m_ready = 4'h0; cnt_clr = 1'b0;
    test_reset();
    test_basic_route();
    test_backpressure();
    test_throughput();
    test_simultaneous();
    test_cnt_wrap();
    test_clr_collision();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
